// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op codes, FSM states and default width for the HI/LO mul/div unit
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIN
    } state_e;

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - request/result bundle between the control unit and the mul/div unit
interface muldiv_if #(parameter int WIDTH = 32);

    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, hi, lo);

endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 iteration: shift-add multiply or restoring shift-subtract divide
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_m,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shift;
    logic           w_ge;

    always_comb begin
        w_sum   = {1'b0, i_hi} + {1'b0, {WIDTH{i_lo[0]}} & i_m};
        // Remainder is kept below the divisor, so the shifted partial needs only one extra bit.
        w_shift = {i_hi, i_lo[WIDTH-1]};
        w_ge    = w_shift >= {1'b0, i_m};
        if (i_div) begin
            o_hi = w_ge ? WIDTH'(w_shift - {1'b0, i_m}) : w_shift[WIDTH-1:0];
            o_lo = {i_lo[WIDTH-2:0], w_ge};
        end else begin
            o_hi = w_sum[WIDTH:1];
            o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative signed/unsigned mul/div owning the HI/LO pair, start/busy/done handshake
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic    i_clk,
    input  logic    i_rst,
    muldiv_if.slave bus
);

    state_e           r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi, r_lo, r_acc_hi, r_acc_lo, r_m;
    logic             r_done, r_div, r_neg_q, r_neg_r;

    logic             w_idle, w_calc, w_fin, w_accept, w_signed, w_a_neg, w_b_neg, w_is_div;
    logic [WIDTH-1:0] w_a_mag, w_b_mag, w_step_hi, w_step_lo;
    logic [2*WIDTH-1:0] w_prod, w_prod_fix;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_CALC;
            ST_CALC: if (r_cnt == '0) w_next = ST_FIN;
            ST_FIN:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_idle = (r_state == ST_IDLE);
        w_calc = (r_state == ST_CALC);
        w_fin  = (r_state == ST_FIN);
    end

    always_comb begin
        w_accept   = w_idle && bus.start && !bus.op[2];
        w_is_div   = bus.op[1];
        w_signed   = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        w_a_neg    = w_signed && bus.a[WIDTH-1];
        w_b_neg    = w_signed && bus.b[WIDTH-1];
        w_a_mag    = w_a_neg ? -bus.a : bus.a;
        w_b_mag    = w_b_neg ? -bus.b : bus.b;
        w_prod     = {r_acc_hi, r_acc_lo};
        w_prod_fix = r_neg_q ? -w_prod : w_prod;
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_div (r_div),
        .i_hi  (r_acc_hi),
        .i_lo  (r_acc_lo),
        .i_m   (r_m),
        .o_hi  (w_step_hi),
        .o_lo  (w_step_lo)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_m      <= '0;
            r_div    <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else begin
            r_done <= w_fin;
            if (w_accept) begin
                r_cnt    <= CNT_W'(WIDTH - 1);
                r_div    <= w_is_div;
                r_acc_hi <= '0;
                r_acc_lo <= w_is_div ? w_a_mag : w_b_mag;
                r_m      <= w_is_div ? w_b_mag : w_a_mag;
                r_neg_r  <= w_a_neg;
                // Divide-by-zero must yield an all-ones quotient even when the dividend is negative.
                r_neg_q  <= (w_a_neg ^ w_b_neg) && !(w_is_div && bus.b == '0);
            end else if (w_calc) begin
                r_cnt    <= r_cnt - 1'b1;
                r_acc_hi <= w_step_hi;
                r_acc_lo <= w_step_lo;
            end
            if (w_idle && bus.start && bus.op == OP_MTHI) r_hi <= bus.a;
            if (w_idle && bus.start && bus.op == OP_MTLO) r_lo <= bus.a;
            if (w_fin) begin
                if (r_div) begin
                    r_lo <= r_neg_q ? -r_acc_lo : r_acc_lo;
                    r_hi <= r_neg_r ? -r_acc_hi : r_acc_hi;
                end else begin
                    {r_hi, r_lo} <= w_prod_fix;
                end
            end
        end
    end

    assign bus.busy = !w_idle;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed vector bench for muldiv_unit at WIDTH=32
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int edges, output int busyc);
        edges = 0;
        busyc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.done) return;
            if (bus.busy) busyc++;
            @(posedge clk);
            edges++;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL done_timeout: got no done within 100 cycles, expected a done pulse");
    endtask

    task automatic expect_no_done(input string name, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            seen = seen | bus.done;
        end
        check(name, {31'b0, seen}, 32'd0);
    endtask

    initial begin
        int edges, busyc;
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.a     = '0;
        bus.b     = '0;

        vecs[0] = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E};
        vecs[3] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5] = '{OP_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
        vecs[6] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[7] = '{OP_MULT,  32'h00000007, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6};
        vecs[8] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[9] = '{OP_MULTU, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_hi", bus.hi, 32'd0);
        check("reset_lo", bus.lo, 32'd0);
        check("reset_busy", {31'b0, bus.busy}, 32'd0);
        check("reset_done", {31'b0, bus.done}, 32'd0);

        for (int v = 0; v < 10; v++) begin
            issue(vecs[v].op, vecs[v].a, vecs[v].b);
            wait_done(edges, busyc);
            check($sformatf("v%0d_latency_edges", v), edges + 1, 32'd34);
            check($sformatf("v%0d_busy_cycles", v), busyc, 32'd33);
            check($sformatf("v%0d_busy_at_done", v), {31'b0, bus.busy}, 32'd0);
            check($sformatf("v%0d_hi", v), bus.hi, vecs[v].exp_hi);
            check($sformatf("v%0d_lo", v), bus.lo, vecs[v].exp_lo);
            @(negedge clk);
            check($sformatf("v%0d_done_pulse_width", v), {31'b0, bus.done}, 32'd0);
        end

        issue(OP_MTHI, 32'hCAFEF00D, 32'h0);
        @(negedge clk);
        check("mthi_hi", bus.hi, 32'hCAFEF00D);
        check("mthi_lo_kept", bus.lo, vecs[9].exp_lo);
        check("mthi_busy", {31'b0, bus.busy}, 32'd0);
        check("mthi_done", {31'b0, bus.done}, 32'd0);

        issue(OP_MTLO, 32'h12345678, 32'h0);
        @(negedge clk);
        check("mtlo_lo", bus.lo, 32'h12345678);
        check("mtlo_hi_kept", bus.hi, 32'hCAFEF00D);

        issue(OP_MULT, 32'd3, 32'd4);
        repeat (5) @(posedge clk);
        issue(OP_MTLO, 32'hDEADBEEF, 32'h0);
        issue(OP_MTHI, 32'hBAADF00D, 32'h0);
        issue(OP_DIVU, 32'd99, 32'd9);
        @(negedge clk);
        check("busy_mtlo_ignored", bus.lo, 32'h12345678);
        check("busy_mthi_ignored", bus.hi, 32'hCAFEF00D);
        wait_done(edges, busyc);
        check("busy_mult_hi", bus.hi, 32'h00000000);
        check("busy_mult_lo", bus.lo, 32'h0000000C);
        expect_no_done("busy_div_ignored_no_done", 40);

        issue(OP_DIV, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midreset_hi", bus.hi, 32'd0);
        check("midreset_lo", bus.lo, 32'd0);
        check("midreset_busy", {31'b0, bus.busy}, 32'd0);
        expect_no_done("midreset_no_done", 40);

        issue(OP_MULT, 32'd6, 32'd7);
        wait_done(edges, busyc);
        check("post_reset_hi", bus.hi, 32'd0);
        check("post_reset_lo", bus.lo, 32'd42);

        issue(3'b110, 32'h0000FFFF, 32'h1);
        @(negedge clk);
        check("reserved_busy", {31'b0, bus.busy}, 32'd0);
        expect_no_done("reserved_no_done", 5);
        check("reserved_hi", bus.hi, 32'd0);
        check("reserved_lo", bus.lo, 32'd42);

        @(negedge clk);
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.op    = OP_MTHI;
        bus.a     = 32'h00000055;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("rst_start_mthi_hi", bus.hi, 32'd0);
        check("rst_start_lo", bus.lo, 32'd0);

        @(negedge clk);
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.op    = OP_MULT;
        bus.a     = 32'd5;
        bus.b     = 32'd5;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("rst_start_mult_busy", {31'b0, bus.busy}, 32'd0);
        expect_no_done("rst_start_mult_no_done", 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
